// File: rtl/led_seq_pkg.sv
// ---------------------------------------------------------------------------
// led_seq_pkg
// Shared encodings for the LED colour sequencer: per-channel mode codes and
// the bounce direction flag.
// ---------------------------------------------------------------------------
package led_seq_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/led_seq_channel.sv
// ---------------------------------------------------------------------------
// led_seq_channel
// One colour channel. Holds the colour code and the bounce direction and
// advances them on each tick according to the channel mode.
// Ports:
//   clk    - clock, all state on posedge
//   rst    - synchronous active-high reset (colour=LO, dir=UP)
//   tick   - single-cycle advance strobe from the prescaler
//   mode   - HOLD / UP / DOWN / BOUNCE, sampled on the tick edge
//   colour - registered colour code, always within [LO..HI]
// ---------------------------------------------------------------------------
module led_seq_channel
    import led_seq_pkg::*;
#(
    parameter int W  = 3,
    parameter int LO = 1,
    parameter int HI = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic [1:0]   mode,
    output logic [W-1:0] colour
);

    localparam logic [W-1:0] LO_C  = W'(LO);
    localparam logic [W-1:0] HI_C  = W'(HI);
    // Turn-around targets for bounce; only meaningful when LO < HI.
    localparam logic [W-1:0] LO_P1 = W'(LO + 1);
    localparam logic [W-1:0] HI_M1 = W'(HI - 1);
    localparam logic [W-1:0] ONE_C = W'(1);

    logic [W-1:0] colour_r;
    logic [W-1:0] colour_nxt_s;
    logic         dir_r;
    logic         dir_nxt_s;

    // Next colour/direction for the next tick; wraps are explicit so the
    // W-bit arithmetic never overflows.
    always_comb begin
        colour_nxt_s = colour_r;
        dir_nxt_s    = dir_r;
        if (LO == HI) begin
            // Single legal code: every mode pins the colour.
            colour_nxt_s = LO_C;
        end else begin
            case (mode)
                MODE_HOLD: begin
                    colour_nxt_s = colour_r;
                end
                MODE_UP: begin
                    if (colour_r == HI_C) begin
                        colour_nxt_s = LO_C;
                    end else begin
                        colour_nxt_s = colour_r + ONE_C;
                    end
                end
                MODE_DOWN: begin
                    if (colour_r == LO_C) begin
                        colour_nxt_s = HI_C;
                    end else begin
                        colour_nxt_s = colour_r - ONE_C;
                    end
                end
                MODE_BOUNCE: begin
                    // Turn around without repeating the end value.
                    if (dir_r == DIR_UP) begin
                        if (colour_r == HI_C) begin
                            colour_nxt_s = HI_M1;
                            dir_nxt_s    = DIR_DN;
                        end else begin
                            colour_nxt_s = colour_r + ONE_C;
                        end
                    end else begin
                        if (colour_r == LO_C) begin
                            colour_nxt_s = LO_P1;
                            dir_nxt_s    = DIR_UP;
                        end else begin
                            colour_nxt_s = colour_r - ONE_C;
                        end
                    end
                end
                default: begin
                    colour_nxt_s = colour_r;
                end
            endcase
        end
    end

    // Colour and direction registers; reset wins over a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            colour_r <= LO_C;
            dir_r    <= DIR_UP;
        end else if (tick) begin
            colour_r <= colour_nxt_s;
            dir_r    <= dir_nxt_s;
        end else begin
            colour_r <= colour_r;
            dir_r    <= dir_r;
        end
    end

    assign colour = colour_r;

endmodule

// File: rtl/led_sequencer.sv
// ---------------------------------------------------------------------------
// led_sequencer
// Multi-channel LED colour sequencer. While the (synchronised) button is
// held, a prescaler emits a tick every div+1 cycles; each tick advances every
// channel by its own mode. Releasing the button freezes all colours.
// Ports:
//   clk    - clock, all state on posedge
//   rst    - synchronous active-high reset
//   button - asynchronous push-button, high = run
//   div    - tick period minus one (0 = tick every cycle), sampled each cycle
//   mode   - per-channel mode, channel i at [2i+1:2i]
//   colour - per-channel registered colour, channel i at [W*i+W-1:W*i]
//   step   - registered pulse, high in the cycle new colours first appear
// ---------------------------------------------------------------------------
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int W     = 3,
    parameter int NCH   = 2,
    parameter int LO    = 1,
    parameter int HI    = 6,
    parameter int DIV_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               button,
    input  logic [DIV_W-1:0]   div,
    input  logic [2*NCH-1:0]   mode,
    output logic [W*NCH-1:0]   colour,
    output logic               step
);

    localparam logic [DIV_W-1:0] CNT_ZERO = DIV_W'(0);
    localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

    logic             btn_meta_r;
    logic             btn_s_r;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cnt_nxt_s;
    logic             tick_s;
    logic             step_r;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_r <= 1'b0;
            btn_s_r    <= 1'b0;
        end else begin
            btn_meta_r <= button;
            btn_s_r    <= btn_meta_r;
        end
    end

    // Equality (not >=) on purpose: if div drops below cnt the counter runs
    // on and wraps through zero before the next tick.
    assign tick_s = btn_s_r && (cnt_r == div);

    // Prescaler next count: idle at zero while released, restart on tick.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (!btn_s_r) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (tick_s) begin
            cnt_nxt_s = CNT_ZERO;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    // Prescaler counter and step pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= CNT_ZERO;
            step_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            step_r <= tick_s;
        end
    end

    assign step = step_r;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        led_seq_channel #(
            .W  (W),
            .LO (LO),
            .HI (HI)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .tick   (tick_s),
            .mode   (mode[2*i +: 2]),
            .colour (colour[W*i +: W])
        );
    end

endmodule
